pong_game_ctrl: RTL and testbench

Top-level game sequencer for Pong. Owns the match state machine (idle, serve delay, rally, point award, game over), keeps both players' scores, and drives the `o_Game_Active` enable that gates the paddle and ball controllers. It samples the ball and paddle positions in game units and detects a miss at either paddle column.

---
 rtl/pong_game_ctrl.sv | 158 +++++++++++++++
 tb/tb_pong_game_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve/rally/point/game-over FSM, score keeping and
// miss detection at both paddle columns. Gates the paddle and ball controllers via o_Game_Active.
module pong_game_ctrl #(
    parameter int c_GAME_WIDTH    = 40,
    parameter int c_GAME_HEIGHT   = 30,
    parameter int c_PADDLE_HEIGHT = 6,
    parameter int c_P1_PADDLE_X   = 0,
    parameter int c_P2_PADDLE_X   = 39,
    parameter int c_SCORE_LIMIT   = 9,
    parameter int c_SERVE_DELAY   = 25000000
) (
    input  logic                                 i_Clk,
    input  logic                                 i_Rst_L,
    input  logic                                 i_Start,
    input  logic [$clog2(c_GAME_WIDTH)-1:0]      i_Ball_X,
    input  logic [$clog2(c_GAME_HEIGHT)-1:0]     i_Ball_Y,
    input  logic [$clog2(c_GAME_HEIGHT)-1:0]     i_P1_Paddle_Y,
    input  logic [$clog2(c_GAME_HEIGHT)-1:0]     i_P2_Paddle_Y,
    output logic                                 o_Game_Active,
    output logic [$clog2(c_SCORE_LIMIT+1)-1:0]   o_P1_Score,
    output logic [$clog2(c_SCORE_LIMIT+1)-1:0]   o_P2_Score,
    output logic                                 o_Point_Pulse,
    output logic [1:0]                           o_Winner,
    output logic [2:0]                           o_State
);

    localparam int W_X = $clog2(c_GAME_WIDTH);
    localparam int W_Y = $clog2(c_GAME_HEIGHT);
    localparam int W_S = $clog2(c_SCORE_LIMIT+1);
    localparam int W_C = (c_SERVE_DELAY > 1) ? $clog2(c_SERVE_DELAY) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SERVE     = 3'd1;
    localparam logic [2:0] S_PLAY      = 3'd2;
    localparam logic [2:0] S_POINT     = 3'd3;
    localparam logic [2:0] S_GAME_OVER = 3'd4;

    localparam logic [W_S-1:0] SCORE_MAX = W_S'(c_SCORE_LIMIT);
    localparam logic [W_C-1:0] CNT_LAST  = W_C'(c_SERVE_DELAY - 1);
    localparam logic [W_X-1:0] P1_COL    = W_X'(c_P1_PADDLE_X);
    localparam logic [W_X-1:0] P2_COL    = W_X'(c_P2_PADDLE_X);
    localparam logic [W_Y:0]   PAD_H     = (W_Y+1)'(c_PADDLE_HEIGHT);

    logic [2:0]     r_State;
    logic [W_C-1:0] r_Serve_Cnt;
    logic [W_S-1:0] r_P1_Score;
    logic [W_S-1:0] r_P2_Score;
    logic [1:0]     r_Winner;
    logic           r_Game_Active;
    logic           r_Point_Pulse;
    logic           r_Start_Q;

    logic [2:0]     w_State_Nxt;
    logic [W_C-1:0] w_Cnt_Nxt;
    logic [W_S-1:0] w_P1_Nxt;
    logic [W_S-1:0] w_P2_Nxt;
    logic [1:0]     w_Win_Nxt;
    logic           w_Start_Evt;
    logic           w_P1_Miss;
    logic           w_P2_Miss;
    logic [W_Y:0]   w_Ball_Y;
    logic [W_Y:0]   w_P1_Top;
    logic [W_Y:0]   w_P2_Top;

    assign w_Start_Evt = i_Start & ~r_Start_Q;

    // One extra bit so top + paddle height never wraps.
    assign w_Ball_Y  = {1'b0, i_Ball_Y};
    assign w_P1_Top  = {1'b0, i_P1_Paddle_Y};
    assign w_P2_Top  = {1'b0, i_P2_Paddle_Y};
    assign w_P1_Miss = (i_Ball_X == P1_COL) &&
                       ((w_Ball_Y < w_P1_Top) || (w_Ball_Y >= w_P1_Top + PAD_H));
    assign w_P2_Miss = (i_Ball_X == P2_COL) &&
                       ((w_Ball_Y < w_P2_Top) || (w_Ball_Y >= w_P2_Top + PAD_H));

    always_comb begin
        w_State_Nxt = r_State;
        w_Cnt_Nxt   = r_Serve_Cnt;
        w_P1_Nxt    = r_P1_Score;
        w_P2_Nxt    = r_P2_Score;
        w_Win_Nxt   = r_Winner;
        case (r_State)
            S_IDLE, S_GAME_OVER: begin
                if (w_Start_Evt) begin
                    w_P1_Nxt    = '0;
                    w_P2_Nxt    = '0;
                    w_Win_Nxt   = 2'b00;
                    w_Cnt_Nxt   = '0;
                    w_State_Nxt = S_SERVE;
                end
            end
            S_SERVE: begin
                if (r_Serve_Cnt == CNT_LAST) begin
                    w_Cnt_Nxt   = '0;
                    w_State_Nxt = S_PLAY;
                end else begin
                    w_Cnt_Nxt = r_Serve_Cnt + 1'b1;
                end
            end
            S_PLAY: begin
                // A P1 miss takes priority when both columns report a miss.
                if (w_P1_Miss) begin
                    w_State_Nxt = S_POINT;
                    if (r_P2_Score != SCORE_MAX) w_P2_Nxt = r_P2_Score + 1'b1;
                end else if (w_P2_Miss) begin
                    w_State_Nxt = S_POINT;
                    if (r_P1_Score != SCORE_MAX) w_P1_Nxt = r_P1_Score + 1'b1;
                end
            end
            S_POINT: begin
                if (r_P1_Score == SCORE_MAX) begin
                    w_Win_Nxt   = 2'b01;
                    w_State_Nxt = S_GAME_OVER;
                end else if (r_P2_Score == SCORE_MAX) begin
                    w_Win_Nxt   = 2'b10;
                    w_State_Nxt = S_GAME_OVER;
                end else begin
                    w_Cnt_Nxt   = '0;
                    w_State_Nxt = S_SERVE;
                end
            end
            default: begin
                w_Cnt_Nxt   = '0;
                w_State_Nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State       <= S_IDLE;
            r_Serve_Cnt   <= '0;
            r_P1_Score    <= '0;
            r_P2_Score    <= '0;
            r_Winner      <= 2'b00;
            r_Game_Active <= 1'b0;
            r_Point_Pulse <= 1'b0;
            r_Start_Q     <= 1'b1;
        end else begin
            r_State       <= w_State_Nxt;
            r_Serve_Cnt   <= w_Cnt_Nxt;
            r_P1_Score    <= w_P1_Nxt;
            r_P2_Score    <= w_P2_Nxt;
            r_Winner      <= w_Win_Nxt;
            r_Game_Active <= (w_State_Nxt == S_PLAY);
            r_Point_Pulse <= (w_State_Nxt == S_POINT);
            r_Start_Q     <= i_Start;
        end
    end

    assign o_State       = r_State;
    assign o_Game_Active = r_Game_Active;
    assign o_Point_Pulse = r_Point_Pulse;
    assign o_P1_Score    = r_P1_Score;
    assign o_P2_Score    = r_P2_Score;
    assign o_Winner      = r_Winner;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: per-cycle expectations are queued as
// stimulus is driven and compared after the following clock edge.
module tb_pong_game_ctrl;

    logic       i_Clk = 1'b0;
    logic       i_Rst_L;
    logic       i_Start;
    logic [5:0] i_Ball_X;
    logic [4:0] i_Ball_Y;
    logic [4:0] i_P1_Paddle_Y;
    logic [4:0] i_P2_Paddle_Y;
    logic       o_Game_Active;
    logic [1:0] o_P1_Score;
    logic [1:0] o_P2_Score;
    logic       o_Point_Pulse;
    logic [1:0] o_Winner;
    logic [2:0] o_State;

    int n_chk = 0;
    int n_err = 0;

    typedef struct packed {
        logic [2:0] st;
        logic       act;
        logic [1:0] p1;
        logic [1:0] p2;
        logic       pulse;
        logic [1:0] win;
    } exp_t;

    exp_t q[$];

    pong_game_ctrl #(.c_SCORE_LIMIT(2), .c_SERVE_DELAY(4)) dut (
        .i_Clk         (i_Clk),
        .i_Rst_L       (i_Rst_L),
        .i_Start       (i_Start),
        .i_Ball_X      (i_Ball_X),
        .i_Ball_Y      (i_Ball_Y),
        .i_P1_Paddle_Y (i_P1_Paddle_Y),
        .i_P2_Paddle_Y (i_P2_Paddle_Y),
        .o_Game_Active (o_Game_Active),
        .o_P1_Score    (o_P1_Score),
        .o_P2_Score    (o_P2_Score),
        .o_Point_Pulse (o_Point_Pulse),
        .o_Winner      (o_Winner),
        .o_State       (o_State)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input int st, input int act, input int p1,
                                input int p2, input int pulse, input int win);
        exp_t e;
        e.st = 3'(st); e.act = 1'(act); e.p1 = 2'(p1);
        e.p2 = 2'(p2); e.pulse = 1'(pulse); e.win = 2'(win);
        return e;
    endfunction

    task automatic cyc(input string tag, input exp_t e);
        exp_t a;
        q.push_back(e);
        @(posedge i_Clk);
        #1;
        a = q.pop_front();
        chk({tag, ".state"}, 32'(o_State), 32'(a.st));
        chk({tag, ".active"}, 32'(o_Game_Active), 32'(a.act));
        chk({tag, ".p1"}, 32'(o_P1_Score), 32'(a.p1));
        chk({tag, ".p2"}, 32'(o_P2_Score), 32'(a.p2));
        chk({tag, ".pulse"}, 32'(o_Point_Pulse), 32'(a.pulse));
        chk({tag, ".winner"}, 32'(o_Winner), 32'(a.win));
    endtask

    task automatic serve_then_play(input int n, input int p1, input int p2);
        for (int i = 0; i < n; i++) cyc("serve", mk(1, 0, p1, p2, 0, 0));
        cyc("play", mk(2, 1, p1, p2, 0, 0));
    endtask

    task automatic ball(input int x, input int y);
        i_Ball_X = 6'(x);
        i_Ball_Y = 5'(y);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_Rst_L = 1'b0;
        i_Start = 1'b1;
        i_P1_Paddle_Y = 5'd12;
        i_P2_Paddle_Y = 5'd12;
        ball(20, 15);
        #1;
        chk("rst.state", 32'(o_State), 0);
        chk("rst.active", 32'(o_Game_Active), 0);
        chk("rst.scores", 32'({o_P1_Score, o_P2_Score}), 0);
        chk("rst.pulse", 32'(o_Point_Pulse), 0);
        chk("rst.winner", 32'(o_Winner), 0);
        repeat (2) @(posedge i_Clk);
        @(negedge i_Clk) i_Rst_L = 1'b1;

        // Start held through reset release is not an event
        cyc("hold0", mk(0, 0, 0, 0, 0, 0));
        cyc("hold1", mk(0, 0, 0, 0, 0, 0));
        i_Start = 1'b0;
        cyc("idle", mk(0, 0, 0, 0, 0, 0));

        i_Start = 1'b1;
        cyc("start", mk(1, 0, 0, 0, 0, 0));
        i_Start = 1'b0;
        serve_then_play(3, 0, 0);

        // P1 misses below its paddle
        ball(0, 20);
        cyc("p1miss", mk(3, 0, 0, 1, 1, 0));
        ball(20, 15);
        serve_then_play(4, 0, 1);

        // P2 paddle boundary rows 12 and 17 are hits, 18 is a miss
        ball(39, 12);
        cyc("p2top", mk(2, 1, 0, 1, 0, 0));
        ball(39, 17);
        cyc("p2bot", mk(2, 1, 0, 1, 0, 0));
        ball(0, 12);
        cyc("p1top", mk(2, 1, 0, 1, 0, 0));
        ball(0, 17);
        cyc("p1bot", mk(2, 1, 0, 1, 0, 0));
        ball(39, 18);
        cyc("p2miss", mk(3, 0, 1, 1, 1, 0));
        ball(20, 15);
        serve_then_play(4, 1, 1);

        // P2 misses above its paddle: P1 reaches the limit
        ball(39, 0);
        cyc("win_pt", mk(3, 0, 2, 1, 1, 0));
        i_Start = 1'b1;
        cyc("gover", mk(4, 0, 2, 1, 0, 1));
        for (int i = 0; i < 3; i++) begin
            ball((i == 1) ? 0 : 39, 0);
            cyc("gover_hold", mk(4, 0, 2, 1, 0, 1));
        end
        i_Start = 1'b0;
        cyc("gover_rel", mk(4, 0, 2, 1, 0, 1));
        i_Start = 1'b1;
        cyc("restart", mk(1, 0, 0, 0, 0, 0));
        i_Start = 1'b0;
        ball(20, 15);
        serve_then_play(3, 0, 0);

        ball(39, 25);
        cyc("p2miss2", mk(3, 0, 1, 0, 1, 0));
        ball(20, 15);
        serve_then_play(4, 1, 0);

        // Asynchronous reset in the middle of a rally
        #2;
        i_Rst_L = 1'b0;
        #1;
        chk("arst.active", 32'(o_Game_Active), 0);
        chk("arst.p1", 32'(o_P1_Score), 0);
        chk("arst.p2", 32'(o_P2_Score), 0);
        chk("arst.state", 32'(o_State), 0);
        @(negedge i_Clk) i_Rst_L = 1'b1;
        cyc("post_rst", mk(0, 0, 0, 0, 0, 0));

        chk("queue_empty", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
